// File: rtl/nibble_assembler.sv
// nibble_assembler
// Collects 4-bit nibbles from a valid/ready stream into one wide word and
// presents the finished word on a valid/ready output. A word ends when its
// last slot is filled or when in_last marks an early end. Slots that no
// nibble reached read as zero.
//
// Build option: define NIBBLE_ASSEMBLER_MSB_FIRST_EN to place nibble k at
// bits [W-1-4k -: 4] instead of the default [4k +: 4].
//
// Reset is synchronous and active-high on rst.

module nibble_assembler #(
  parameter int NIBBLES = 4,
  parameter int LW      = $clog2(NIBBLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_nib,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_word,
  output logic [LW-1:0]          out_len
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

  // Registered state
  logic [0:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  buf_r;
  logic [LW-1:0] len_r;
  logic          valid_r;

  // Next-state values
  logic [0:0]    state_s;
  logic [CW-1:0] cnt_s;
  logic [W-1:0]  buf_s;
  logic [LW-1:0] len_s;
  logic          valid_s;

  // Handshake and datapath helpers
  logic          in_ready_s;
  logic          accept_s;
  logic          release_s;
  logic [W-1:0]  base_s;
  logic [CW-1:0] slot_s;
  logic          ends_word_s;

  // Writes one nibble into the given slot and leaves every other slot alone.
  function automatic logic [W-1:0] place_nibble(
    input logic [W-1:0]  word,
    input logic [CW-1:0] slot,
    input logic [3:0]    nib
  );
    logic [W-1:0] res;
    res = word;
    for (int k = 0; k < NIBBLES; k++) begin
      if (slot == CW'(k)) begin
`ifdef NIBBLE_ASSEMBLER_MSB_FIRST_EN
        res[W-1-4*k -: 4] = nib;
`else
        res[4*k +: 4] = nib;
`endif
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Input-side readiness: open while collecting, follows out_ready while a
  // word is held (so the slot-0 nibble of the next word can enter on the
  // same edge the held word leaves), and closed during reset.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_COLLECT: in_ready_s = 1'b1;
        ST_FULL:    in_ready_s = out_ready;
        default:    in_ready_s = 1'b0;
      endcase
    end
  end

  assign in_ready = in_ready_s;

  // Handshake events and where an incoming nibble lands. When the held word
  // leaves on this edge the incoming nibble goes into a cleared buffer.
  always_comb begin
    accept_s  = in_valid && in_ready_s;
    release_s = (state_r == ST_FULL) && out_ready;
    if (release_s) begin
      base_s = {W{1'b0}};
      slot_s = {CW{1'b0}};
    end else begin
      base_s = buf_r;
      slot_s = cnt_r;
    end
    ends_word_s = (slot_s == CW'(NIBBLES - 1)) || in_last;
  end

  // Next-state computation for the two-state collect/hold machine.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    buf_s   = buf_r;
    len_s   = len_r;
    valid_s = valid_r;
    if (accept_s) begin
      buf_s = place_nibble(base_s, slot_s, in_nib);
      if (ends_word_s) begin
        state_s = ST_FULL;
        valid_s = 1'b1;
        len_s   = LW'(slot_s) + LW'(1'b1);
        cnt_s   = {CW{1'b0}};
      end else begin
        state_s = ST_COLLECT;
        valid_s = 1'b0;
        len_s   = len_r;
        cnt_s   = slot_s + CW'(1'b1);
      end
    end else if (release_s) begin
      state_s = ST_COLLECT;
      valid_s = 1'b0;
      buf_s   = {W{1'b0}};
      cnt_s   = {CW{1'b0}};
      len_s   = len_r;
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
      buf_s   = buf_r;
      len_s   = len_r;
      valid_s = valid_r;
    end
  end

  // State registers; reset discards any partial or held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_COLLECT;
      cnt_r   <= {CW{1'b0}};
      buf_r   <= {W{1'b0}};
      len_r   <= {LW{1'b0}};
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      buf_r   <= buf_s;
      len_r   <= len_s;
      valid_r <= valid_s;
    end
  end

  assign out_valid = valid_r;
  assign out_word  = buf_r;
  assign out_len   = len_r;

endmodule

// File: tb/tb_nibble_assembler.sv
// Directed self-checking bench for nibble_assembler (NIBBLES = 4).
// Inputs change 1 time unit after the rising edge; outputs, in_ready and
// output handshakes are observed on the falling edge.

module tb_nibble_assembler;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nib;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [2:0]  out_len;

  int n_checks;
  int n_fail;
  int valid_cycles;
  int stalls;

  logic [15:0] q_word[$];
  logic [2:0]  q_len[$];

`ifdef NIBBLE_ASSEMBLER_MSB_FIRST_EN
  localparam logic [15:0] E_FULL  = 16'h1234;
  localparam logic [15:0] E_SHORT = 16'hAB00;
  localparam logic [15:0] E_SECND = 16'h5678;
  localparam logic [15:0] E_PART5 = 16'h5000;
  localparam logic [15:0] E_W56   = 16'h5600;
`else
  localparam logic [15:0] E_FULL  = 16'h4321;
  localparam logic [15:0] E_SHORT = 16'h00BA;
  localparam logic [15:0] E_SECND = 16'h8765;
  localparam logic [15:0] E_PART5 = 16'h0005;
  localparam logic [15:0] E_W56   = 16'h0065;
`endif

  nibble_assembler #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nib    (in_nib),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_len   (out_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every completed output transfer and every cycle out_valid is high.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      valid_cycles = valid_cycles + 1;
      if (out_ready) begin
        q_word.push_back(out_word);
        q_len.push_back(out_len);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one nibble and waits (bounded) until it is accepted.
  task automatic send(input logic [3:0] nib, input logic last);
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_nib   = nib;
    in_last  = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      accepted = in_ready;
      tick();
      if (accepted) break;
      stalls = stalls + 1;
    end
    if (!accepted) check_eq("send_timeout", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp_w, input logic [2:0] exp_l);
    logic [15:0] w;
    logic [2:0]  l;
    if (q_word.size() != 0) begin
      w = q_word.pop_front();
      l = q_len.pop_front();
      check_eq({tag, "_word"}, {16'd0, w}, {16'd0, exp_w});
      check_eq({tag, "_len"}, {29'd0, l}, {29'd0, exp_l});
    end else begin
      check_eq({tag, "_present"}, q_word.size(), 32'd1);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    valid_cycles = 0;
    stalls       = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_nib    = 4'hF;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    // Reset state
    @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_word", {16'd0, out_word}, 32'd0);
    check_eq("rst_out_len", {29'd0, out_len}, 32'd0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Full word
    valid_cycles = 0;
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
    repeat (4) tick();
    check_eq("full_count", q_word.size(), 32'd1);
    pop_check("full", E_FULL, 3'd4);
    check_eq("full_valid_cycles", valid_cycles, 32'd1);

    // Short word
    send(4'hA, 1'b0); send(4'hB, 1'b1);
    repeat (3) tick();
    check_eq("short_count", q_word.size(), 32'd1);
    pop_check("short", E_SHORT, 3'd2);

    // Back-to-back, no bubbles
    stalls = 0;
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    repeat (3) tick();
    check_eq("b2b_stalls", stalls, 32'd0);
    check_eq("b2b_count", q_word.size(), 32'd2);
    pop_check("b2b_first", E_FULL, 3'd4);
    pop_check("b2b_second", E_SECND, 3'd4);

    // Backpressure
    out_ready = 1'b0;
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
    in_valid = 1'b1;
    in_nib   = 4'h5;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_out_word", {16'd0, out_word}, {16'd0, E_FULL});
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_after_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bp_after_buf", {16'd0, out_word}, {16'd0, E_PART5});
    tick();
    send(4'h6, 1'b1);
    repeat (3) tick();
    check_eq("bp_count", q_word.size(), 32'd2);
    pop_check("bp_held", E_FULL, 3'd4);
    pop_check("bp_next", E_W56, 3'd2);

    // Reset mid-word
    send(4'h9, 1'b0); send(4'h9, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_nib   = 4'h7;
    @(negedge clk);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_out_word", {16'd0, out_word}, 32'd0);
    check_eq("midrst_out_len", {29'd0, out_len}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
    repeat (4) tick();
    check_eq("midrst_count", q_word.size(), 32'd1);
    pop_check("midrst", E_FULL, 3'd4);

    // in_last on the final slot
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b1);
    repeat (5) tick();
    check_eq("lastfinal_count", q_word.size(), 32'd1);
    pop_check("lastfinal", E_FULL, 3'd4);
    @(negedge clk);
    check_eq("lastfinal_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
